// File: rtl/braid_seq_pkg.sv
// Shared types and constants for the braid pulse sequencer.
// Holds the sequencer state encoding, the default descriptor layout and
// the adiabatic minimum pulse width used by the optional width clamp.
package braid_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    PULSE,
    GAP,
    REPEAT,
    HALT
  } seq_state_t;

  localparam int DESC_WIDTH_W = 8;
  localparam int DESC_REP_W   = 4;

  // 2 GHz clock, 5 ns minimum adiabatic pulse.
  localparam int ADIABATIC_MIN_TICKS = 10;

  // One braid pulse descriptor as presented on the command port.
  typedef struct packed {
    logic [DESC_WIDTH_W-1:0] width;
    logic [DESC_WIDTH_W-1:0] gap;
    logic [DESC_REP_W-1:0]   reps;
  } braid_desc_t;

endpackage

// File: rtl/braid_cmd_fifo.sv
// Command descriptor FIFO for the braid pulse sequencer.
// Synchronous, power-of-two depth, with a flush that empties it in one cycle.
// full, empty and pop_data depend only on internal registers, never on the
// push/pop inputs of the same cycle. A push while full is taken only when a
// pop retires the head entry in the same cycle.
module braid_cmd_fifo
  import braid_seq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage write port.
  // NOTE: the storage array has no reset; empty/full come from the pointers,
  // so stale contents are never observable and the array can map to LUT RAM.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; flush wins over push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/braid_pulse_sequencer.sv
// Braid pulse sequencer: upstream stage of the Sigma-X safety interlock.
// Buffers (width, gap, repeat) descriptors and plays each out as a train of
// drive pulses, strobing start_trigger with the pulse width one cycle before
// every pulse. SCRAM cuts pulse_out in the same cycle and halts the block,
// flushing all pending work until the operator clears it.
// Optional build macro SEQ_ADIABATIC_CLAMP_EN: discard descriptors whose
// non-zero width is below MIN_WIDTH and raise the sticky cmd_err flag.
module braid_pulse_sequencer
  import braid_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH_W    = 8,
  parameter int REP_W      = 4,
  parameter int MIN_WIDTH  = ADIABATIC_MIN_TICKS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WIDTH_W-1:0] cmd_width,
  input  logic [WIDTH_W-1:0] cmd_gap,
  input  logic [REP_W-1:0]   cmd_reps,
  input  logic               scram_in,
  input  logic               scram_clr,
  output logic               start_trigger,
  output logic [WIDTH_W-1:0] pulse_width_ticks,
  output logic               pulse_out,
  output logic               busy,
  output logic               halted,
  output logic               done,
  output logic               cmd_err
);

  localparam int DESC_W = 2 * WIDTH_W + REP_W;
  localparam logic [REP_W-1:0] ONE_REP = REP_W'(1);

  seq_state_t         state;
  logic [WIDTH_W-1:0] cnt;
  logic [REP_W-1:0]   reps_left;
  logic [WIDTH_W-1:0] lat_width;
  logic [WIDTH_W-1:0] lat_gap;
  logic               pulse_reg;
  logic               ready_en;

  logic [DESC_W-1:0]  fifo_wdata;
  logic [DESC_W-1:0]  fifo_rdata;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_flush;
  logic               fifo_full;
  logic               fifo_empty;

  logic [WIDTH_W-1:0] f_width;
  logic [WIDTH_W-1:0] f_gap;
  logic [REP_W-1:0]   f_reps;
  logic [REP_W-1:0]   f_reps_eff;
  logic               reject;
  logic               last_rep;

  // Command port and FIFO hookup.
  assign fifo_wdata = {cmd_width, cmd_gap, cmd_reps};
  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_pop   = (state == IDLE) && !fifo_empty && !scram_in;
  assign fifo_flush = scram_in || (state == HALT);

  assign f_width    = fifo_rdata[DESC_W-1 -: WIDTH_W];
  assign f_gap      = fifo_rdata[REP_W +: WIDTH_W];
  assign f_reps     = fifo_rdata[REP_W-1:0];
  assign f_reps_eff = (f_reps == '0) ? ONE_REP : f_reps;
  assign last_rep   = (reps_left == ONE_REP);

  // ready_en keeps cmd_ready low through reset and until the first clock after it.
  assign cmd_ready = ready_en && !fifo_full && (state != HALT);

  // The drive gate is cut combinationally so SCRAM takes effect with zero latency.
  assign pulse_out = pulse_reg && !scram_in;

  braid_cmd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DESC_W)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef SEQ_ADIABATIC_CLAMP_EN
  localparam logic [WIDTH_W-1:0] MIN_W = WIDTH_W'(MIN_WIDTH);

  assign reject = (f_width != '0) && (f_width < MIN_W);

  // Sticky error flag: set whenever a too-short descriptor is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_err <= 1'b0;
    end else if (fifo_pop && reject) begin
      cmd_err <= 1'b1;
    end
  end
`else
  // Without the clamp every width passes; the interlock enforces the limit.
  assign reject  = 1'b0;
  assign cmd_err = 1'b0;

  // MIN_WIDTH only matters to the clamp; sink it so the parameter stays referenced.
  logic unused_min_width;
  assign unused_min_width = (MIN_WIDTH != 0);
`endif

  // Command port opens on the first clock after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Sequencer FSM with registered strobes and status outputs.
  // NOTE: all state here is updated with non-blocking assignments so every
  // branch reads the pre-edge values of state, cnt and reps_left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      reps_left         <= '0;
      lat_width         <= '0;
      lat_gap           <= '0;
      pulse_reg         <= 1'b0;
      start_trigger     <= 1'b0;
      pulse_width_ticks <= '0;
      busy              <= 1'b0;
      halted            <= 1'b0;
      done              <= 1'b0;
    end else begin
      start_trigger <= 1'b0;
      done          <= 1'b0;
      if (scram_in) begin
        // SCRAM overrides every transition, including pops and completion.
        state     <= HALT;
        pulse_reg <= 1'b0;
        busy      <= 1'b1;
        halted    <= 1'b1;
        cnt       <= '0;
        reps_left <= '0;
        lat_width <= '0;
        lat_gap   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!fifo_empty && !reject) begin
              lat_width         <= f_width;
              lat_gap           <= f_gap;
              reps_left         <= f_reps_eff;
              pulse_width_ticks <= f_width;
              start_trigger     <= 1'b1;
              busy              <= 1'b1;
              state             <= ARM;
            end
          end
          ARM: begin
            if (lat_width != '0) begin
              pulse_reg <= 1'b1;
              cnt       <= lat_width;
              state     <= PULSE;
            end else if (lat_gap != '0) begin
              cnt   <= lat_gap;
              state <= GAP;
            end else begin
              done  <= last_rep;
              state <= REPEAT;
            end
          end
          PULSE: begin
            if (cnt == WIDTH_W'(1)) begin
              pulse_reg <= 1'b0;
              if (lat_gap != '0) begin
                cnt   <= lat_gap;
                state <= GAP;
              end else begin
                done  <= last_rep;
                state <= REPEAT;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          GAP: begin
            if (cnt == WIDTH_W'(1)) begin
              done  <= last_rep;
              state <= REPEAT;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          REPEAT: begin
            reps_left <= reps_left - 1'b1;
            if (!last_rep) begin
              pulse_width_ticks <= lat_width;
              start_trigger     <= 1'b1;
              state             <= ARM;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          HALT: begin
            if (scram_clr) begin
              busy   <= 1'b0;
              halted <= 1'b0;
              state  <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/braid_pulse_sequencer.md
Name: braid_pulse_sequencer

Overview:
- Upstream stage of the Sigma-X safety interlock in the Kintex-7 control core.
- Accepts braid pulse descriptors (width, gap, repeat) through a valid/ready command port and buffers them in a small FIFO.
- Plays each descriptor out as a train of Sigma-X drive pulses, presenting each pulse's start_trigger and pulse_width_ticks to the interlock one cycle before the pulse begins.
- Stops immediately and flushes all pending work when the interlock's SCRAM is raised.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.
- WIDTH_W, 8, bit width of the pulse width and gap fields in clock ticks.
- REP_W, 4, bit width of the repeat count field.
- MIN_WIDTH, 10, adiabatic minimum pulse width in ticks (2 GHz clock, 5 ns); used only by the optional feature.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command descriptor valid.
- cmd_ready  out  1  sequencer can accept a descriptor.
- cmd_width  in  WIDTH_W  pulse high time, ticks.
- cmd_gap  in  WIDTH_W  low time after each pulse, ticks.
- cmd_reps  in  REP_W  pulses per descriptor; 0 is treated as 1.
- scram_in  in  1  SCRAM from the interlock, level-sensitive.
- scram_clr  in  1  single-cycle operator clear of the halt.
- start_trigger  out  1  single-cycle strobe to the interlock.
- pulse_width_ticks  out  WIDTH_W  width of the current pulse; held stable between strobes.
- pulse_out  out  1  Sigma-X drive gate.
- busy  out  1  sequencer is not IDLE.
- halted  out  1  sequencer is in HALT.
- done  out  1  single-cycle strobe when a descriptor completes.
- cmd_err  out  1  sticky; set only when the optional feature is compiled in.

Behaviour:
- Reset is asynchronous and active-high.
- Reset values: all outputs 0, FIFO empty, state IDLE; cmd_ready goes to 1 on the first clock edge after rst deasserts.
- Handshake: a descriptor is pushed when cmd_valid && cmd_ready.
- cmd_ready = !fifo_full && state != HALT.
- The FIFO accepts a push while full only if a pop happens in the same cycle; cmd_ready still reads 0 in that cycle.
- States:
  - IDLE: if the FIFO is non-empty, pop the descriptor, latch width, gap and reps (reps 0 becomes 1), go to ARM. Latency from push into an empty FIFO to ARM: 2 cycles.
  - ARM: 1 cycle. start_trigger = 1; pulse_width_ticks = latched width, registered so it is valid in the same cycle as the strobe. Next state: PULSE, or GAP if width = 0 (pulse_out is never raised in that case).
  - PULSE: pulse_out is high for exactly width cycles; a down-counter reloads on entry. Next state: GAP, or REPEAT if gap = 0.
  - GAP: pulse_out is low for exactly gap cycles. Next state: REPEAT.
  - REPEAT: decrement reps.
    - If reps remain: go to ARM, so every pulse gets its own strobe.
    - Otherwise: done = 1 for this cycle; go to IDLE.
  - HALT: entered from any state on the cycle after scram_in = 1.
    - Flush the FIFO and drop the latched descriptor; done is not asserted.
    - Remain in HALT while scram_in = 1.
    - Leave for IDLE only when scram_clr = 1 && scram_in = 0.
- pulse_out = pulse_reg && !scram_in. This is the only combinational path in the block; it guarantees zero-cycle cutoff.
- scram_in takes priority over every other transition in the same cycle, including done and pops.
- Counters are WIDTH_W bits, with no wrap: width 255 gives exactly 255 high cycles.
- Reset during a pulse: pulse_out drops asynchronously and the FIFO is emptied.

Optional Feature:
- Macro: SEQ_ADIABATIC_CLAMP_EN.
- When defined:
  - In IDLE, a popped descriptor with 0 < width < MIN_WIDTH is discarded. No ARM, no strobe, no done.
  - cmd_err is set to 1 and stays set until rst.
  - The next FIFO entry is processed on the following cycle.
- When undefined: cmd_err is tied to 0, all widths pass through, and the downstream interlock alone enforces the adiabatic limit.

Decomposition:
- Shared package braid_seq_pkg holds:
  - the state enum: IDLE, ARM, PULSE, GAP, REPEAT, HALT;
  - the descriptor struct: width, gap, reps;
  - the ADIABATIC_MIN_TICKS = 10 constant.
- One sub-module: braid_cmd_fifo. Synchronous FIFO with push, pop, flush, full and empty; registered outputs.

Test Plan:
- Push {width 12, gap 4, reps 1} after reset -> cmd_ready=1; start_trigger strobes once with pulse_width_ticks=12; pulse_out high 12 cycles then low 4; done strobes in the REPEAT cycle.
- Push {width 10, gap 0, reps 3} -> 3 strobes, 3 pulses of 10 cycles separated by one ARM cycle and one REPEAT cycle each; a single done.
- Push 4 descriptors back-to-back while the first is running -> cmd_ready=0 once the FIFO is full, no descriptor lost; all complete in order with 4 done strobes.
- Raise scram_in at cycle 5 of a width-20 pulse -> pulse_out=0 in that same cycle; HALT and halted=1 next cycle; FIFO empty; cmd_ready=0; no done; scram_clr while scram_in=1 is ignored; scram_clr after scram_in drops returns to IDLE.
- Push {width 0, gap 6, reps 2} -> 2 strobes with pulse_width_ticks=0; pulse_out never high; done after about 2×(1+6+1) cycles.
- With SEQ_ADIABATIC_CLAMP_EN, push {width 5} then {width 15} -> width 5 is discarded and cmd_err=1; width 15 runs normally; without the macro, width 5 pulses for 5 cycles and cmd_err=0.
